tlight_monitor: RTL and testbench

TLIGHT_MONITOR -- requirements
Module: tlight_monitor

---
 rtl/tlight_pkg.sv | 33 +++
 rtl/tlight_decode.sv | 26 ++
 rtl/tlight_monitor.sv | 115 +++++++++++
 tb/tb_tlight_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlight_pkg.sv
// Shared traffic-light definitions: phase encoding, lamp patterns and successor order.
package tlight_pkg;

    typedef enum logic [1:0] {
        PH_RED       = 2'd0,
        PH_RED_AMBER = 2'd1,
        PH_GREEN     = 2'd2,
        PH_AMBER     = 2'd3
    } phase_t;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } mon_state_t;

    localparam int unsigned PAT_W = 3;

    // Lamp patterns ordered {r,a,g}
    localparam logic [PAT_W-1:0] PAT_RED       = 3'b100;
    localparam logic [PAT_W-1:0] PAT_RED_AMBER = 3'b110;
    localparam logic [PAT_W-1:0] PAT_GREEN     = 3'b001;
    localparam logic [PAT_W-1:0] PAT_AMBER     = 3'b010;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:       next_phase = PH_RED_AMBER;
            PH_RED_AMBER: next_phase = PH_GREEN;
            PH_GREEN:     next_phase = PH_AMBER;
            default:      next_phase = PH_RED;
        endcase
    endfunction

endpackage

// File: rtl/tlight_decode.sv
// Combinational lamp-pattern decoder plus successor lookup for the tracked phase.
module tlight_decode
    import tlight_pkg::*;
(
    input  logic [PAT_W-1:0] pattern,
    input  phase_t           cur,
    output phase_t           dec_c,
    output logic             legal_c,
    output phase_t           succ_c
);

    always_comb begin
        dec_c   = PH_RED;
        legal_c = 1'b1;
        case (pattern)
            PAT_RED:       dec_c = PH_RED;
            PAT_RED_AMBER: dec_c = PH_RED_AMBER;
            PAT_GREEN:     dec_c = PH_GREEN;
            PAT_AMBER:     dec_c = PH_AMBER;
            default:       legal_c = 1'b0;
        endcase
    end

    assign succ_c = next_phase(cur);

endmodule

// File: rtl/tlight_monitor.sv
// Traffic-light sequence monitor: locks onto a legal lamp sequence and flags
// illegal patterns, skipped phases and stalls.
module tlight_monitor
    import tlight_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r,
    input  logic       a,
    input  logic       g,
    input  logic       clr_err,
    output logic [1:0] phase,
    output logic       locked,
    output logic       err_pulse,
    output logic       fault,
    output logic [7:0] err_count,
    output logic [7:0] cycle_count
);

    // Sized so MAX_HOLD itself is representable; the counter saturates there and never wraps
    localparam int unsigned HOLD_W  = $clog2(MAX_HOLD + 2);
    localparam int unsigned COUNT_W = 8;

    mon_state_t         state_q, state_nx;
    phase_t             phase_q, phase_nx;
    logic [HOLD_W-1:0]  hold_q, hold_nx;
    logic               pulse_q, pulse_nx;
    logic               fault_q, fault_nx;
    logic [COUNT_W-1:0] err_q, err_nx;
    logic [COUNT_W-1:0] cyc_q, cyc_nx;

    phase_t dec_c;
    phase_t succ_c;
    logic   legal_c;
    logic   fault_hit_c;

    tlight_decode u_decode (
        .pattern (PAT_W'({r, a, g})),
        .cur     (phase_q),
        .dec_c   (dec_c),
        .legal_c (legal_c),
        .succ_c  (succ_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNLOCKED;
            phase_q <= PH_RED;
            hold_q  <= '0;
            pulse_q <= 1'b0;
            fault_q <= 1'b0;
            err_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_nx;
            phase_q <= phase_nx;
            hold_q  <= hold_nx;
            pulse_q <= pulse_nx;
            fault_q <= fault_nx;
            err_q   <= err_nx;
            cyc_q   <= cyc_nx;
        end
    end

    always_comb begin
        state_nx    = state_q;
        phase_nx    = phase_q;
        hold_nx     = hold_q;
        pulse_nx    = 1'b0;
        fault_nx    = fault_q & ~clr_err;
        err_nx      = err_q;
        cyc_nx      = cyc_q;
        fault_hit_c = 1'b0;

        case (state_q)
            ST_UNLOCKED: begin
                if (legal_c) begin
                    state_nx = ST_LOCKED;
                    phase_nx = dec_c;
                    hold_nx  = '0;
                end
            end
            default: begin
                if (legal_c && dec_c == phase_q) begin
                    if (hold_q == HOLD_W'(MAX_HOLD)) fault_hit_c = 1'b1;
                    else                              hold_nx = hold_q + HOLD_W'(1);
                end else if (legal_c && dec_c == succ_c) begin
                    phase_nx = dec_c;
                    hold_nx  = '0;
                    if (phase_q == PH_AMBER) cyc_nx = cyc_q + COUNT_W'(1);
                end else begin
                    fault_hit_c = 1'b1;
                end
            end
        endcase

        // A new fault takes priority over a simultaneous clear; phase keeps its last value
        if (fault_hit_c) begin
            state_nx = ST_UNLOCKED;
            pulse_nx = 1'b1;
            fault_nx = 1'b1;
            if (err_q != {COUNT_W{1'b1}}) err_nx = err_q + COUNT_W'(1);
        end
    end

    assign phase       = 2'(phase_q);
    assign locked      = (state_q == ST_LOCKED);
    assign err_pulse   = pulse_q;
    assign fault       = fault_q;
    assign err_count   = err_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_tlight_monitor.sv
// Bench for tlight_monitor: reference model feeds a scoreboard, plus directed spot checks.
module tb_tlight_monitor;

    localparam int unsigned MAX_HOLD = 3;

    logic       clk;
    logic       rst;
    logic       r, a, g;
    logic       clr_err;
    logic [1:0] phase;
    logic       locked;
    logic       err_pulse;
    logic       fault;
    logic [7:0] err_count;
    logic [7:0] cycle_count;

    tlight_monitor #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .r           (r),
        .a           (a),
        .g           (g),
        .clr_err     (clr_err),
        .phase       (phase),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .fault       (fault),
        .err_count   (err_count),
        .cycle_count (cycle_count)
    );

    typedef struct {
        logic [1:0] phase;
        logic       locked;
        logic       err_pulse;
        logic       fault;
        logic [7:0] err_count;
        logic [7:0] cycle_count;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    logic       m_locked;
    logic [1:0] m_phase;
    int         m_hold;
    logic       m_pulse;
    logic       m_fault;
    int         m_errc;
    int         m_cycc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic [2:0] pat, input logic c, input logic rs);
        logic       legal;
        logic [1:0] dp;
        logic       flt;
        exp_t       e;
        legal = 1'b1;
        dp    = 2'd0;
        flt   = 1'b0;
        case (pat)
            3'b100:  dp = 2'd0;
            3'b110:  dp = 2'd1;
            3'b001:  dp = 2'd2;
            3'b010:  dp = 2'd3;
            default: legal = 1'b0;
        endcase
        if (rs) begin
            m_locked = 1'b0; m_phase = 2'd0; m_hold = 0; m_pulse = 1'b0;
            m_fault = 1'b0; m_errc = 0; m_cycc = 0;
        end else begin
            m_pulse = 1'b0;
            if (!m_locked) begin
                if (legal) begin
                    m_locked = 1'b1; m_phase = dp; m_hold = 0;
                end
            end else if (legal && dp == m_phase) begin
                if (m_hold >= int'(MAX_HOLD)) flt = 1'b1;
                else m_hold = m_hold + 1;
            end else if (legal && dp == 2'(m_phase + 2'd1)) begin
                if (m_phase == 2'd3) m_cycc = (m_cycc + 1) % 256;
                m_phase = dp; m_hold = 0;
            end else begin
                flt = 1'b1;
            end
            if (c) m_fault = 1'b0;
            if (flt) begin
                m_locked = 1'b0; m_fault = 1'b1; m_pulse = 1'b1;
                if (m_errc < 255) m_errc = m_errc + 1;
            end
        end
        e.phase = m_phase; e.locked = m_locked; e.err_pulse = m_pulse; e.fault = m_fault;
        e.err_count = 8'(m_errc); e.cycle_count = 8'(m_cycc);
        sb.push_back(e);
    endtask

    // Drive one sample at the falling edge; outputs are settled 2 time units after the rising edge
    task automatic drive(input logic [2:0] pat, input logic c, input logic rs);
        @(negedge clk);
        {r, a, g} = pat;
        clr_err   = c;
        rst       = rs;
        model_step(pat, c, rs);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard comparator
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            sb_e = sb.pop_front();
            checks++;
            if ({phase, locked, err_pulse, fault, err_count, cycle_count} !==
                {sb_e.phase, sb_e.locked, sb_e.err_pulse, sb_e.fault, sb_e.err_count, sb_e.cycle_count}) begin
                failures++;
                $display("FAIL scoreboard t=%0t got ph=%0d lk=%0b p=%0b f=%0b ec=%0d cc=%0d want ph=%0d lk=%0b p=%0b f=%0b ec=%0d cc=%0d",
                         $time, phase, locked, err_pulse, fault, err_count, cycle_count,
                         sb_e.phase, sb_e.locked, sb_e.err_pulse, sb_e.fault, sb_e.err_count, sb_e.cycle_count);
            end
        end
    end

    task automatic test_reset();
        drive(3'b000, 1'b0, 1'b1);
        drive(3'b100, 1'b1, 1'b1);
        checks++;
        if ({phase, locked, err_pulse, fault, err_count, cycle_count} !== 20'd0) begin
            failures++;
            $display("FAIL reset_state got ph=%0d lk=%0b p=%0b f=%0b ec=%0d cc=%0d want all 0",
                     phase, locked, err_pulse, fault, err_count, cycle_count);
        end
        drive(3'b000, 1'b0, 1'b0);
        drive(3'b111, 1'b0, 1'b0);
        drive(3'b011, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || fault !== 1'b0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL unlocked_ignore got lk=%0b f=%0b ec=%0d want 0 0 0", locked, fault, err_count);
        end
    endtask

    task automatic test_lock_sequence();
        drive(3'b000, 1'b0, 1'b1);
        drive(3'b000, 1'b0, 1'b0);
        drive(3'b001, 1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_on_first_legal got=%0b want=1", locked);
        end
        drive(3'b010, 1'b0, 1'b0);
        drive(3'b100, 1'b0, 1'b0);
        checks++;
        if (cycle_count !== 8'd1) begin
            failures++;
            $display("FAIL lock_cycle_count got=%0d want=1", cycle_count);
        end
        drive(3'b110, 1'b0, 1'b0);
        drive(3'b001, 1'b0, 1'b0);
        checks++;
        if (phase !== 2'd2 || fault !== 1'b0 || err_count !== 8'd0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_final got ph=%0d f=%0b ec=%0d lk=%0b want 2 0 0 1", phase, fault, err_count, locked);
        end
    endtask

    task automatic test_wrong_successor();
        drive(3'b100, 1'b0, 1'b0);
        checks++;
        if (err_pulse !== 1'b1 || fault !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || phase !== 2'd2) begin
            failures++;
            $display("FAIL skip_fault got p=%0b f=%0b ec=%0d lk=%0b ph=%0d want 1 1 1 0 2",
                     err_pulse, fault, err_count, locked, phase);
        end
        drive(3'b100, 1'b0, 1'b0);
        checks++;
        if (err_pulse !== 1'b0 || locked !== 1'b1 || phase !== 2'd0) begin
            failures++;
            $display("FAIL skip_relock got p=%0b lk=%0b ph=%0d want 0 1 0", err_pulse, locked, phase);
        end
    endtask

    task automatic test_hold();
        drive(3'b000, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(3'b110, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b0 || locked !== 1'b1 || phase !== 2'd1) begin
            failures++;
            $display("FAIL hold_limit got f=%0b lk=%0b ph=%0d want 0 1 1", fault, locked, phase);
        end
        drive(3'b110, 1'b0, 1'b0);
        checks++;
        if (fault !== 1'b1 || err_pulse !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL hold_stall got f=%0b p=%0b lk=%0b want 1 1 0", fault, err_pulse, locked);
        end
    endtask

    task automatic test_err_saturate();
        drive(3'b000, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            drive(3'b111, 1'b0, 1'b0);
            drive(3'b100, 1'b0, 1'b0);
        end
        checks++;
        if (err_count !== 8'd255 || locked !== 1'b1) begin
            failures++;
            $display("FAIL err_saturate got ec=%0d lk=%0b want 255 1", err_count, locked);
        end
    endtask

    task automatic test_clr_same_cycle();
        drive(3'b000, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b0);
        drive(3'b110, 1'b0, 1'b0);
        drive(3'b111, 1'b1, 1'b0);
        checks++;
        if (fault !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL clr_vs_fault got f=%0b ec=%0d want 1 1", fault, err_count);
        end
        drive(3'b100, 1'b1, 1'b0);
        checks++;
        if (fault !== 1'b0 || err_count !== 8'd1 || locked !== 1'b1 || cycle_count !== 8'd0) begin
            failures++;
            $display("FAIL clr_only got f=%0b ec=%0d lk=%0b cc=%0d want 0 1 1 0", fault, err_count, locked, cycle_count);
        end
    endtask

    task automatic test_cycle_wrap();
        drive(3'b000, 1'b0, 1'b1);
        drive(3'b100, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            drive(3'b110, 1'b0, 1'b0);
            drive(3'b001, 1'b0, 1'b0);
            drive(3'b010, 1'b0, 1'b0);
            drive(3'b100, 1'b0, 1'b0);
        end
        checks++;
        if (cycle_count !== 8'd0 || locked !== 1'b1 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL cycle_wrap got cc=%0d lk=%0b ec=%0d want 0 1 0", cycle_count, locked, err_count);
        end
        drive(3'b110, 1'b0, 1'b0);
        drive(3'b001, 1'b0, 1'b0);
        drive(3'b010, 1'b0, 1'b0);
        checks++;
        if (phase !== 2'd3 || cycle_count !== 8'd0) begin
            failures++;
            $display("FAIL amber_reached got ph=%0d cc=%0d want 3 0", phase, cycle_count);
        end
        drive(3'b010, 1'b1, 1'b1);
        checks++;
        if ({phase, locked, err_pulse, fault, err_count, cycle_count} !== 20'd0) begin
            failures++;
            $display("FAIL mid_reset got ph=%0d lk=%0b p=%0b f=%0b ec=%0d cc=%0d want all 0",
                     phase, locked, err_pulse, fault, err_count, cycle_count);
        end
    endtask

    initial begin
        rst = 1'b1; r = 1'b0; a = 1'b0; g = 1'b0; clr_err = 1'b0;
        m_locked = 1'b0; m_phase = 2'd0; m_hold = 0; m_pulse = 1'b0;
        m_fault = 1'b0; m_errc = 0; m_cycc = 0;
        test_reset();
        test_lock_sequence();
        test_wrong_successor();
        test_hold();
        test_err_saturate();
        test_clr_same_cycle();
        test_cycle_wrap();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0 pending", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
